// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (I refill / D refill+write-back) arbiter and beat sequencer for single-ported main memory
//   clk, rst_n (sync, active-low)
//   I side: I_Req, I_Tag, I_Line -> I_Grant, I_Done
//   D side: D_Req, D_We, D_Tag, D_Line, D_Wdata -> D_Grant, D_Done, Wr_Word
//   read return: Rd_Valid, Rd_Word, Rd_Data
//   memory: Memory_Read_En, Memory_Write_En, Addr_Tag, Line_number, block_num_Addr, Data_From_RISC,
//           Data_From_Memory, block_num_Mem, Mem_Done
//   Mem_Err: sticky protocol error
//   ARB_D_PRIORITY_EN: D wins every tie instead of round-robin
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_Req,
  input  logic [2:0]  I_Tag,
  input  logic [4:0]  I_Line,
  output logic        I_Grant,
  output logic        I_Done,
  input  logic        D_Req,
  input  logic        D_We,
  input  logic [2:0]  D_Tag,
  input  logic [4:0]  D_Line,
  input  logic [31:0] D_Wdata,
  output logic        D_Grant,
  output logic        D_Done,
  output logic        Rd_Valid,
  output logic [1:0]  Rd_Word,
  output logic [31:0] Rd_Data,
  output logic [1:0]  Wr_Word,
  output logic        Memory_Read_En,
  output logic        Memory_Write_En,
  output logic [2:0]  Addr_Tag,
  output logic [4:0]  Line_number,
  output logic [1:0]  block_num_Addr,
  output logic [31:0] Data_From_RISC,
  input  logic [31:0] Data_From_Memory,
  input  logic [1:0]  block_num_Mem,
  input  logic        Mem_Done,
  output logic        Mem_Err
);
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  state_t st;
  logic [2:0] beat;
  logic side, we, i_ok, d_ok, pick_d, win;
`ifndef ARB_D_PRIORITY_EN
  logic rr;
`endif
  assign Rd_Data = Data_From_Memory;
  assign Rd_Word = block_num_Mem;
  assign block_num_Addr = 2'd0;
  assign Data_From_RISC = Memory_Write_En ? D_Wdata : 32'd0;
  // the side just served sits out the GAP cycle
  always_comb begin
    i_ok = I_Req && !(st == GAP && !side);
    d_ok = D_Req && !(st == GAP && side);
`ifdef ARB_D_PRIORITY_EN
    pick_d = d_ok;
`else
    pick_d = d_ok && (!i_ok || rr);
`endif
    win = i_ok || d_ok;
  end
  // outputs are registered from the next state so they align with the beat they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      beat <= 3'd0;
      side <= 1'b0;
      we <= 1'b0;
`ifndef ARB_D_PRIORITY_EN
      rr <= 1'b0;
`endif
      Addr_Tag <= 3'd0;
      Line_number <= 5'd0;
      I_Grant <= 1'b0;
      D_Grant <= 1'b0;
      I_Done <= 1'b0;
      D_Done <= 1'b0;
      Rd_Valid <= 1'b0;
      Wr_Word <= 2'd0;
      Memory_Read_En <= 1'b0;
      Memory_Write_En <= 1'b0;
      Mem_Err <= 1'b0;
    end else if (st == BUSY) begin
      beat <= beat + 3'd1;
      if (beat == 3'd4) begin
        st <= GAP;
        I_Grant <= 1'b0;
        D_Grant <= 1'b0;
        I_Done <= !side;
        D_Done <= side;
        Rd_Valid <= 1'b0;
        Wr_Word <= 2'd0;
        Memory_Read_En <= 1'b0;
        Memory_Write_En <= 1'b0;
        if (Mem_Done) Mem_Err <= 1'b1;
      end else begin
        // a write only primes the memory counter on beat 0 so block 7 is never written
        Memory_Read_En <= !we;
        Memory_Write_En <= we;
        Rd_Valid <= !we;
        Wr_Word <= we ? beat[1:0] : 2'd0;
        if (beat == 3'd3 && !Mem_Done) Mem_Err <= 1'b1;
      end
    end else begin
      st <= win ? BUSY : IDLE;
      beat <= 3'd0;
      I_Done <= 1'b0;
      D_Done <= 1'b0;
      I_Grant <= win && !pick_d;
      D_Grant <= pick_d;
      Memory_Read_En <= win;
      if (win) begin
        side <= pick_d;
        we <= pick_d && D_We;
        Addr_Tag <= pick_d ? D_Tag : I_Tag;
        Line_number <= pick_d ? D_Line : I_Line;
`ifndef ARB_D_PRIORITY_EN
        rr <= !pick_d;
`endif
      end
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported main memory. It shares the memory between the instruction-cache refill path (I side, read-only) and the data cache (D side, line refill or line write-back). It also generates the enable and beat timing that the memory's internal block counter and Mem_Done flag require. Every transaction moves one full 4-word line selected by {tag, line}.

## Interface
- BEATS, 5: grant length in cycles (1 counter-prime beat + 4 data beats); fixed, not to be overridden.
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  synchronous, active-low reset.
- I_Req  in  1  I-side line refill request, level, held until I_Done.
- I_Tag / I_Line  in  3 / 5  I-side line address.
- I_Grant  out  1  I side owns memory (BUSY beats).
- I_Done  out  1  one-cycle completion pulse.
- D_Req  in  1  D-side request, level, held until D_Done.
- D_We  in  1  with D_Req: 1 = write-back, 0 = refill.
- D_Tag / D_Line  in  3 / 5  D-side line address.
- D_Wdata  in  32  write word for index Wr_Word (combinational from D cache).
- D_Grant / D_Done  out  1 / 1  as I side.
- Rd_Valid  out  1  read data beat valid (beats 1-4 of a read).
- Rd_Word  out  2  word index of Rd_Data (= block_num_Mem).
- Rd_Data  out  32  = Data_From_Memory.
- Wr_Word  out  2  word index D must present on D_Wdata (beat-1, beats 1-4 of a write).
- Memory_Read_En / Memory_Write_En  out  1 / 1  memory enables.
- Addr_Tag / Line_number  out  3 / 5  latched winner address.
- block_num_Addr  out  2  constant 0.
- Data_From_RISC  out  32  D_Wdata during write beats 1-4, else 0.
- Data_From_Memory  in  32 ; block_num_Mem  in  2 ; Mem_Done  in  1.
- Mem_Err  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE, BUSY (3-bit beat counter 0..4), GAP.
- Arbitration happens in IDLE and in GAP. On a winner, latch side, D_We, tag, and line, then enter BUSY with beat 0.
- In GAP, the requester just served is excluded, even if its request is still high.
- Round-robin between the sides: the last-served side loses a tie. Pointer reset value = I wins.
- Read transaction:
  - Memory_Read_En = 1 for beats 0-4.
  - Rd_Valid = 1 on beats 1-4, with Rd_Word = 0,1,2,3 in order.
- Write transaction:
  - Memory_Read_En = 1 on beat 0 only. This advances the memory counter 7->0 without writing block 7.
  - Memory_Write_En = 1 on beats 1-4, with Wr_Word = 0..3.
- After beat 4, go to GAP:
  - Both enables are 0, so the memory counter returns to 7.
  - The granted side's Done pulses high for the GAP cycle only.
  - Grant drops.
- GAP goes to BUSY if the other side requests, otherwise to IDLE.
- A request dropped mid-BUSY does not abort the transaction; it completes and Done still pulses.
- Requester address changes during BUSY are ignored, because the address is latched.
- Mem_Err is set if:
  - Mem_Done is sampled 0 at the posedge ending beat 3, or
  - Mem_Done is sampled 1 at the posedge ending beat 4.
- Mem_Err clears only on reset.

## Timing
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = I, Mem_Err = 0.
- Reset asserted mid-BUSY: the next cycle is IDLE with enables low, and no Done pulse is issued.
- Request sampled in IDLE at posedge N:
  - BUSY beats 0-4 occupy cycles N..N+4.
  - Done is high in cycle N+5.
- Back-to-back requests from alternating sides: one line per 6 cycles.
- A single requester re-requesting needs GAP, then IDLE: 7 cycles.
- Rd_Data/Rd_Word are combinational pass-through. Rd_Valid, Grant, Done, enables, and Wr_Word are registered, decoded from state.

## Configuration
- ARB_D_PRIORITY_EN defined: D wins every tie; the round-robin pointer is removed. The GAP exclusion of the just-served side still applies, so I cannot starve across consecutive D transactions.
- ARB_D_PRIORITY_EN undefined: round-robin as above.

## Test plan
- Reset, then I_Req=1 with tag 3'h5, line 5'h0A:
  - Memory_Read_En is high for 5 cycles.
  - Rd_Valid is high with Rd_Word 0,1,2,3 in order.
  - I_Done pulses once, 6th cycle after the request.
  - Mem_Err stays 0.
- D write-back, with D_Wdata = 32'hA000_0000 + Wr_Word:
  - Memory words 0..3 of {tag,line} hold A0000000..A0000003.
  - Word 7 of the line is unchanged.
  - Memory_Write_En is low on beat 0.
- I_Req and D_Req (read) rise in the same cycle after reset: I is served first, then D immediately after GAP. Total 12 cycles to D_Done.
- Both requesters held continuously for 4 transactions:
  - Without the macro: grants alternate I,D,I,D.
  - With ARB_D_PRIORITY_EN and D_Req asserted first: grants are D,I,D,I.
- rst_n low during beat 2:
  - Next cycle all enables are 0 and no Done pulse is issued.
  - A subsequent request completes normally with Mem_Err=0.
- Mem_Done model forced low for a whole transaction: Mem_Err=1 after beat 3 and stays 1 until reset.
